// File: rtl/ksa_sched_pkg.sv
// Shared types and constants for the ARC4 state-array scheduler.
// State encoding, default geometry and memory depth helper.
package ksa_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RDI,
      ST_CALCJ,
      ST_RDJ,
      ST_WRJ,
      ST_WRI
   } state_e;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_KEY_BYTES = 3;

   function automatic int unsigned mem_depth(input int unsigned data_w);
      return 32'd1 << data_w;
   endfunction

endpackage

// File: rtl/ksa_sched_if.sv
// Start handshake plus single-port S-memory bus of the scheduler.
// master = scheduler side, slave = controller/memory side.
interface ksa_sched_if
   import ksa_sched_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned KEY_BYTES = DEF_KEY_BYTES
);
   logic                          en;
   logic                          rdy;
   logic                          mode;
   logic [DATA_W*KEY_BYTES-1:0]   key;
   logic [DATA_W-1:0]             addr;
   logic [DATA_W-1:0]             wrdata;
   logic                          wren;
   logic [DATA_W-1:0]             rddata;

   modport master (
      input  en, mode, key, rddata,
      output rdy, addr, wrdata, wren
   );

   modport slave (
      output en, mode, key, rddata,
      input  rdy, addr, wrdata, wren
   );
endinterface

// File: rtl/ksa_sched_key_byte_sel.sv
// Combinational key byte selector; byte 0 is the most significant byte.
module key_byte_sel #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned KEY_BYTES = 3,
   parameter int unsigned KIDX_W    = 2
) (
   input  logic [DATA_W*KEY_BYTES-1:0] key,
   input  logic [KIDX_W-1:0]           kidx,
   output logic [DATA_W-1:0]           kbyte
);

   always_comb begin
      kbyte = '0;
      for (int unsigned b = 0; b < KEY_BYTES; b++) begin
         if (kidx == KIDX_W'(b)) kbyte = key[DATA_W*(KEY_BYTES-1-b) +: DATA_W];
      end
   end

endmodule

// File: rtl/ksa_sched.sv
// ARC4 S-array scheduler: identity fill, optionally followed by the KSA swap pass.
// KSA datapath is built only when KSA_SCHED_KSA_EN is defined.
module ksa_sched
   import ksa_sched_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned KEY_BYTES = DEF_KEY_BYTES
) (
   input  logic        clk,
   input  logic        rst,
   ksa_sched_if.master bus
);

   localparam int unsigned       N    = mem_depth(DATA_W);
   localparam logic [DATA_W-1:0] LAST = DATA_W'(N - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   i_q, i_d;
   logic                rdy_q, rdy_d;
   logic [DATA_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wrdata_q, wrdata_d;
   logic                wren_q, wren_d;

`ifdef KSA_SCHED_KSA_EN
   localparam int unsigned     KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KIDX_W-1:0] LAST_K = KIDX_W'(KEY_BYTES - 1);

   logic                        mode_q, mode_d;
   logic [DATA_W*KEY_BYTES-1:0] key_q, key_d;
   logic [DATA_W-1:0]           j_q, j_d;
   logic [DATA_W-1:0]           si_q, si_d;
   logic [KIDX_W-1:0]           kidx_q, kidx_d;
   logic [DATA_W-1:0]           kbyte;

   key_byte_sel #(
      .DATA_W   (DATA_W),
      .KEY_BYTES(KEY_BYTES),
      .KIDX_W   (KIDX_W)
   ) u_key_byte_sel (
      .key  (key_q),
      .kidx (kidx_q),
      .kbyte(kbyte)
   );
`else
   logic unused_inputs;
   assign unused_inputs = ^{bus.mode, bus.key, bus.rddata};
`endif

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      rdy_d    = rdy_q;
      addr_d   = addr_q;
      wrdata_d = wrdata_q;
      wren_d   = 1'b0;
`ifdef KSA_SCHED_KSA_EN
      mode_d   = mode_q;
      key_d    = key_q;
      j_d      = j_q;
      si_d     = si_q;
      kidx_d   = kidx_q;
`endif
      // Outputs are registered, so each branch loads the values of the state being entered.
      case (state_q)
         ST_IDLE: begin
            rdy_d = 1'b1;
            if (bus.en) begin
               state_d  = ST_INIT;
               rdy_d    = 1'b0;
               i_d      = '0;
               addr_d   = '0;
               wrdata_d = '0;
               wren_d   = 1'b1;
`ifdef KSA_SCHED_KSA_EN
               mode_d   = bus.mode;
               key_d    = bus.key;
               j_d      = '0;
               kidx_d   = '0;
`endif
            end
         end
         ST_INIT: begin
            if (i_q == LAST) begin
`ifdef KSA_SCHED_KSA_EN
               if (mode_q) begin
                  state_d = ST_RDI;
                  i_d     = '0;
                  addr_d  = '0;
               end else
`endif
               begin
                  state_d = ST_IDLE;
                  rdy_d   = 1'b1;
               end
            end else begin
               i_d      = i_q + 1'b1;
               addr_d   = i_q + 1'b1;
               wrdata_d = i_q + 1'b1;
               wren_d   = 1'b1;
            end
         end
`ifdef KSA_SCHED_KSA_EN
         ST_RDI: state_d = ST_CALCJ;
         ST_CALCJ: begin
            si_d    = bus.rddata;
            j_d     = j_q + bus.rddata + kbyte;
            addr_d  = j_d;
            state_d = ST_RDJ;
         end
         ST_RDJ: begin
            wrdata_d = si_q;
            wren_d   = 1'b1;
            state_d  = ST_WRJ;
         end
         ST_WRJ: begin
            // S[j] is captured straight into the write-data register; it doubles as sj.
            addr_d   = i_q;
            wrdata_d = bus.rddata;
            wren_d   = 1'b1;
            state_d  = ST_WRI;
         end
         ST_WRI: begin
            kidx_d = (kidx_q == LAST_K) ? '0 : kidx_q + 1'b1;
            if (i_q == LAST) begin
               state_d = ST_IDLE;
               rdy_d   = 1'b1;
            end else begin
               i_d     = i_q + 1'b1;
               addr_d  = i_q + 1'b1;
               state_d = ST_RDI;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         i_q      <= '0;
         rdy_q    <= 1'b1;
         addr_q   <= '0;
         wrdata_q <= '0;
         wren_q   <= 1'b0;
`ifdef KSA_SCHED_KSA_EN
         mode_q   <= 1'b0;
         key_q    <= '0;
         j_q      <= '0;
         si_q     <= '0;
         kidx_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         rdy_q    <= rdy_d;
         addr_q   <= addr_d;
         wrdata_q <= wrdata_d;
         wren_q   <= wren_d;
`ifdef KSA_SCHED_KSA_EN
         mode_q   <= mode_d;
         key_q    <= key_d;
         j_q      <= j_d;
         si_q     <= si_d;
         kidx_q   <= kidx_d;
`endif
      end
   end

   assign bus.rdy    = rdy_q;
   assign bus.addr   = addr_q;
   assign bus.wrdata = wrdata_q;
   assign bus.wren   = wren_q;

endmodule

// File: tb/tb_ksa_sched.sv
// Scoreboard bench for ksa_sched: 8-bit/3-byte and 4-bit/1-byte instances with behavioural S memories.
module tb_ksa_sched;

`ifdef KSA_SCHED_KSA_EN
   localparam bit KSA_ON = 1'b1;
`else
   localparam bit KSA_ON = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ksa_sched_if #(.DATA_W(8), .KEY_BYTES(3)) b8 ();
   ksa_sched_if #(.DATA_W(4), .KEY_BYTES(1)) b4 ();

   ksa_sched #(.DATA_W(8), .KEY_BYTES(3)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.master));
   ksa_sched #(.DATA_W(4), .KEY_BYTES(1)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.master));

   logic [7:0] mem8 [256];
   logic [3:0] mem4 [16];

   always @(posedge clk) begin
      if (b8.wren === 1'b1) mem8[b8.addr] <= b8.wrdata;
      b8.rddata <= mem8[b8.addr];
      if (b4.wren === 1'b1) mem4[b4.addr] <= b4.wrdata;
      b4.rddata <= mem4[b4.addr];
   end

   int checks = 0;
   int errors = 0;
   wr_t q8[$], q4[$], log8[$], log4[$], gq[$];
   logic [7:0] gs [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon8
      wr_t e;
      if (b8.wren === 1'b1) begin
         log8.push_back('{a: b8.addr, d: b8.wrdata});
         if (q8.size() == 0) check("wr8_unexpected", {b8.addr, b8.wrdata}, 32'hFFFF_FFFF);
         else begin
            e = q8.pop_front();
            check("wr8_addr", 32'(b8.addr), 32'(e.a));
            check("wr8_data", 32'(b8.wrdata), 32'(e.d));
         end
      end
   end

   always @(negedge clk) begin : mon4
      wr_t e;
      if (b4.wren === 1'b1) begin
         log4.push_back('{a: {4'h0, b4.addr}, d: {4'h0, b4.wrdata}});
         if (q4.size() == 0) check("wr4_unexpected", {b4.addr, b4.wrdata}, 32'hFFFF_FFFF);
         else begin
            e = q4.pop_front();
            check("wr4_addr", 32'(b4.addr), 32'(e.a));
            check("wr4_data", 32'(b4.wrdata), 32'(e.d));
         end
      end
   end

   // Software reference: identity fill then textbook ARC4 KSA, recorded as a write list.
   task automatic gen(input int dw, input int nb, input bit ksa, input logic [23:0] k);
      int n, j;
      logic [7:0] t, kb, mask;
      n    = int'(ksa_sched_pkg::mem_depth(dw));
      mask = 8'(n - 1);
      gq.delete();
      for (int a = 0; a < n; a++) begin
         gs[a] = 8'(a);
         gq.push_back('{a: 8'(a), d: 8'(a)});
      end
      if (ksa) begin
         j = 0;
         for (int i = 0; i < n; i++) begin
            kb = 8'(k >> (dw * (nb - 1 - (i % nb)))) & mask;
            j  = (j + int'(gs[i]) + int'(kb)) % n;
            gq.push_back('{a: 8'(j), d: gs[i]});
            gq.push_back('{a: 8'(i), d: gs[j]});
            t = gs[i]; gs[i] = gs[j]; gs[j] = t;
         end
      end
   endtask

   task automatic run8(input bit m, input logic [23:0] k, input bit noisy);
      int exp_cyc, cnt, bad;
      bit done;
      gen(8, 3, KSA_ON && m, k);
      foreach (gq[x]) q8.push_back(gq[x]);
      log8.delete();
      exp_cyc = (KSA_ON && m) ? 1537 : 257;
      @(negedge clk); b8.en = 1'b1; b8.mode = m; b8.key = k;
      @(negedge clk); b8.en = 1'b0;
      check("rdy8_busy", 32'(b8.rdy), 32'd0);
      cnt = 1; done = 1'b0;
      while (!done && cnt < exp_cyc + 16) begin
         @(negedge clk); cnt++;
         if (b8.rdy === 1'b1) done = 1'b1;
         else if (noisy) begin
            if (cnt < exp_cyc - 8) begin
               b8.en = (cnt % 5 == 0); b8.key = ~k; b8.mode = ~m;
            end else b8.en = 1'b0;
         end
      end
      b8.en = 1'b0; b8.key = k; b8.mode = m;
      check("done8_cycle", 32'(cnt), 32'(exp_cyc));
      check("q8_drained", 32'(q8.size()), 32'd0);
      bad = 0;
      for (int a = 0; a < 256; a++) if (mem8[a] !== gs[a]) bad++;
      check("mem8_final", 32'(bad), 32'd0);
   endtask

   initial begin
      int cnt, bad;
      bit done;
      b8.en = 1'b1; b8.mode = 1'b0; b8.key = '0;
      b4.en = 1'b1; b4.mode = 1'b0; b4.key = '0;

      // Reset held for 2 cycles with en high: idle values, no start.
      repeat (2) begin
         @(negedge clk);
         check("rst_rdy", 32'(b8.rdy), 32'd1);
         check("rst_wren", 32'(b8.wren), 32'd0);
         check("rst_addr", 32'(b8.addr), 32'd0);
      end
      rst = 1'b0; b8.en = 1'b0; b4.en = 1'b0;
      @(negedge clk);
      check("rst_nostart8", 32'(b8.rdy), 32'd1);
      check("rst_nostart4", 32'(b4.rdy), 32'd1);

      // Init only.
      run8(1'b0, 24'h00033C, 1'b0);
      check("init_cnt", 32'(log8.size()), 32'd256);
      if (log8.size() == 256) begin
         check("init_first", 32'(log8[0]), 32'h0000);
         check("init_last", 32'(log8[255]), 32'hFFFF);
      end

      // Init + KSA with en pulses and key/mode churn while busy.
      run8(1'b1, 24'h00033C, 1'b1);
      check("ksa_cnt", 32'(log8.size()), KSA_ON ? 32'd768 : 32'd256);
      if (KSA_ON && log8.size() == 768) begin
         check("ksa_i0_wrj", 32'(log8[256]), 32'h0000);
         check("ksa_i0_wri", 32'(log8[257]), 32'h0000);
         check("ksa_i1_wrj", 32'(log8[258]), 32'h0401);
         check("ksa_i1_wri", 32'(log8[259]), 32'h0104);
      end

      // Back-to-back with en held high: restart on the first rdy edge.
      gen(8, 3, 1'b0, '0);
      foreach (gq[x]) q8.push_back(gq[x]);
      foreach (gq[x]) q8.push_back(gq[x]);
      log8.delete();
      @(negedge clk); b8.en = 1'b1; b8.mode = 1'b0;
      cnt = 0; done = 1'b0;
      while (!done && cnt < 300) begin
         @(negedge clk); cnt++;
         if (b8.rdy === 1'b1) done = 1'b1;
      end
      check("b2b_first_done", 32'(cnt), 32'd257);
      @(negedge clk); cnt++;
      check("b2b_restart", 32'(b8.rdy), 32'd0);
      done = 1'b0;
      while (!done && cnt < 600) begin
         @(negedge clk); cnt++;
         if (b8.rdy === 1'b1) begin done = 1'b1; b8.en = 1'b0; end
      end
      b8.en = 1'b0;
      check("b2b_second_done", 32'(cnt), 32'd514);
      check("b2b_writes", 32'(log8.size()), 32'd512);
      check("b2b_drained", 32'(q8.size()), 32'd0);

      // Reset mid-operation (KSA i=100, or init i=100 without KSA).
      gen(8, 3, KSA_ON, 24'h00033C);
      foreach (gq[x]) q8.push_back(gq[x]);
      log8.delete();
      @(negedge clk); b8.en = 1'b1; b8.mode = 1'b1; b8.key = 24'h00033C;
      @(negedge clk); b8.en = 1'b0;
      cnt = 0;
      while (log8.size() < (KSA_ON ? 456 : 100) && cnt < 2000) begin
         @(negedge clk); cnt++;
      end
      check("midrst_reached", 32'(log8.size() >= (KSA_ON ? 456 : 100)), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_rdy", 32'(b8.rdy), 32'd1);
      check("midrst_wren", 32'(b8.wren), 32'd0);
      check("midrst_addr", 32'(b8.addr), 32'd0);
      q8.delete();
      @(negedge clk); rst = 1'b0;
      run8(1'b1, 24'h00033C, 1'b0);
      check("restart_cnt", 32'(log8.size()), KSA_ON ? 32'd768 : 32'd256);

      // Small geometry: DATA_W=4, KEY_BYTES=1, key=F.
      gen(4, 1, KSA_ON, 24'h00000F);
      foreach (gq[x]) q4.push_back(gq[x]);
      log4.delete();
      @(negedge clk); b4.en = 1'b1; b4.mode = 1'b1; b4.key = 4'hF;
      @(negedge clk); b4.en = 1'b0;
      cnt = 1; done = 1'b0;
      while (!done && cnt < 130) begin
         @(negedge clk); cnt++;
         if (b4.rdy === 1'b1) done = 1'b1;
      end
      check("done4_cycle", 32'(cnt), KSA_ON ? 32'd97 : 32'd17);
      check("wr4_cnt", 32'(log4.size()), KSA_ON ? 32'd48 : 32'd16);
      check("q4_drained", 32'(q4.size()), 32'd0);
      if (KSA_ON && log4.size() == 48) begin
         check("ksa4_i0_wrj", 32'(log4[16]), 32'h0F00);
         check("ksa4_i0_wri", 32'(log4[17]), 32'h000F);
      end
      bad = 0;
      for (int a = 0; a < 16; a++) if (mem4[a] !== gs[a][3:0]) bad++;
      check("mem4_final", 32'(bad), 32'd0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
